// File: rtl/bist_pkg.sv
// Shared types and constants for the subcircuit BIST driver.
// State encoding, LFSR taps, MISR polynomial and seed fallback.
package bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_CUT,
      RUN,
      FLUSH,
      COMPARE,
      DONE
   } bist_state_t;

   localparam logic [7:0]  LFSR_TAPS = 8'hB8;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [7:0]  SEED_SAFE = 8'h01;

   // Fibonacci step: feedback from bits 7,5,4,3 shifted into bit 0
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_misr16.sv
// 16-bit serial-input MISR used to compact the CUT response.
// Clear wins over enable; reset is asynchronous.
module bist_misr16
   import bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   input  logic        din,
   output logic [15:0] sig
);

   // Shift left, fold in the polynomial on carry-out, xor the response bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= 16'h0000;
      end else if (clr) begin
         sig <= 16'h0000;
      end else if (en) begin
         sig <= {sig[14:0], 1'b0}
              ^ (sig[15] ? MISR_POLY : 16'h0000)
              ^ {15'b0, din};
      end
   end

endmodule

// File: rtl/subckt_bist_driver.sv
// BIST driver for 4-in/1-out benchmark subcircuits: LFSR patterns in,
// MISR signature out, golden compare raises the trojan flag.
module subckt_bist_driver
   import bist_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS = 200,
   parameter int unsigned CUT_LAT      = 2,
   parameter logic [7:0]  LFSR_SEED    = 8'h01,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic        I1294_clk,
   input  logic        I1301_rst,
   input  logic        start,
   input  logic        cut_out,
   output logic [3:0]  cut_in,
   output logic        cut_rst_n,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        trojan_flag,
   output logic [15:0] signature
);

   localparam logic [7:0] SEED =
      (LFSR_SEED == 8'h00) ? SEED_SAFE : LFSR_SEED;
   localparam logic [7:0] LAST_PAT   = 8'(NUM_PATTERNS - 1);
   localparam logic [7:0] LAST_FLUSH = 8'(CUT_LAT - 1);

   bist_state_t state;
   logic [7:0]  cnt;
   logic [7:0]  lfsr;
   logic [15:0] misr_sig;
   logic        is_run;
   logic        misr_clr;
   logic [CUT_LAT-1:0] vld;
   logic [CUT_LAT:0]   vld_sh;

   assign is_run   = (state == RUN);
   assign misr_clr = (state == RST_CUT);
   assign vld_sh   = {vld, is_run};

   // Valid line marks when each applied pattern's response is ready
   always_ff @(posedge I1294_clk or posedge I1301_rst) begin
      if (I1301_rst) begin
         vld <= '0;
      end else begin
         vld <= vld_sh[CUT_LAT-1:0];
      end
   end

   bist_misr16 u_misr (
      .clk (I1294_clk),
      .rst (I1301_rst),
      .en  (vld[CUT_LAT-1]),
      .clr (misr_clr),
      .din (cut_out),
      .sig (misr_sig)
   );

   // Run sequencer with registered outputs
   always_ff @(posedge I1294_clk or posedge I1301_rst) begin
      if (I1301_rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         lfsr        <= 8'd0;
         cut_in      <= 4'd0;
         cut_rst_n   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         trojan_flag <= 1'b0;
         signature   <= 16'h0000;
      end else begin
         done      <= 1'b0;
         cut_in    <= 4'd0;
         cut_rst_n <= (state != RST_CUT);
         busy      <= (state != IDLE) && (state != DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= RST_CUT;
                  cnt         <= 8'd0;
                  pass        <= 1'b0;
                  trojan_flag <= 1'b0;
                  signature   <= 16'h0000;
               end
            end
            RST_CUT: begin
               lfsr <= SEED;
               if (cnt == 8'd1) begin
                  cnt   <= 8'd0;
                  state <= RUN;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RUN: begin
               cut_in <= lfsr[3:0];
               lfsr   <= lfsr_next(lfsr);
               if (cnt == LAST_PAT) begin
                  cnt   <= 8'd0;
                  state <= FLUSH;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            FLUSH: begin
               if (cnt == LAST_FLUSH) begin
                  cnt   <= 8'd0;
                  state <= COMPARE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            COMPARE: begin
               signature   <= misr_sig;
               pass        <= (misr_sig == GOLDEN_SIG);
               trojan_flag <= (misr_sig != GOLDEN_SIG);
               state       <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/subckt_bist_driver.md
Name: subckt_bist_driver

Overview:
- Built-in self-test driver for the 4-input / 1-output sequential benchmark subcircuits used in trojan detection.
- Generates pseudo-random input patterns with an LFSR and drives them into the circuit under test (CUT).
- Compacts the CUT's single-bit response into a 16-bit MISR signature.
- Compares the signature against a golden value and raises a trojan flag on mismatch. It instantiates beside each CUT in the test harness.

Parameters:
- NUM_PATTERNS, 200: number of patterns applied per run (1..255).
- CUT_LAT, 2: CUT input-to-output latency in clocks (1..4).
- LFSR_SEED, 8'h01: LFSR start value. 8'h00 is replaced by 8'h01.
- GOLDEN_SIG, 16'h0000: expected fault-free signature.

Ports:
- I1294_clk  in  1  clock; all flops rising-edge.
- I1301_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request. Ignored unless the block is in IDLE.
- cut_out  in  1  CUT response bit.
- cut_in  out  4  pattern bits to CUT {I1207,I1359,I1215,I1239}, MSB first.
- cut_rst_n  out  1  active-low reset to the CUT.
- busy  out  1  high from RST_CUT through COMPARE.
- done  out  1  one-cycle pulse in the DONE state.
- pass  out  1  signature matched; held until the next start.
- trojan_flag  out  1  equals !pass after a completed run; held until the next start.
- signature  out  16  final MISR value; held until the next start.

Behaviour:
- Reset values (asynchronous, all registered outputs): cut_in=0, cut_rst_n=0, busy=0, done=0, pass=0, trojan_flag=0, signature=0, state=IDLE. A reset mid-run aborts immediately. No partial results survive.
- FSM states and transitions:
  - IDLE: cut_rst_n=1. On start, go to RST_CUT and clear pass, trojan_flag and signature.
  - RST_CUT: 2 cycles with cut_rst_n=0. Load LFSR=seed, MISR=0, counters=0.
  - RUN: NUM_PATTERNS cycles. In each cycle cut_in=lfsr[3:0] (registered), then the LFSR advances.
  - FLUSH: CUT_LAT cycles with cut_in=0, draining responses.
  - COMPARE: 1 cycle. Latch signature=MISR, pass=(MISR==GOLDEN_SIG), trojan_flag=!pass.
  - DONE: 1 cycle with done=1, then return to IDLE.
- Timing: with the start-sampling edge as cycle 0, RUN occupies cycles 3..N+2 and done is high in cycle N+CUT_LAT+4.
- LFSR (8-bit Fibonacci): fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}. From seed 01 the sequence is 01, 02, 04, 08, 11, ...
- MISR update: next = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 0) ^ {15'b0, cut_out}.
- Response capture: the MISR absorbs cut_out exactly once per applied pattern, CUT_LAT cycles after that pattern first appears on cut_in. Exactly NUM_PATTERNS updates occur per run. This is implemented with a CUT_LAT-deep valid shift line that is fed 1 in RUN and 0 otherwise.
- start while busy, or in the same cycle as DONE: ignored, with no queuing.
- start asserted during reset release: ignored until the first clock edge in IDLE.
- Pattern counter: 8-bit, with terminal compare at NUM_PATTERNS-1 and no wrap.

Decomposition:
- Package bist_pkg holds:
  - the state enum (IDLE, RST_CUT, RUN, FLUSH, COMPARE, DONE);
  - LFSR tap mask 8'hB8;
  - MISR polynomial 16'h1021;
  - seed-sanitise constant 8'h01.
- Sub-module bist_misr16 contains the 16-bit MISR with enable, synchronous clear, 1-bit serial input and asynchronous reset. The LFSR stays inline.

Test Plan:
- N=4, LAT=2, cut_out model is a 2-stage delay of cut_in[0] -> cut_in sequence 1,2,4,8 in cycles 3..6; MISR inputs 1,0,0,0; signature 16'h0008.
- N=1, cut_out tied 1 -> signature 16'h0001; GOLDEN=16'h0001 gives pass=1, trojan_flag=0, and done in cycle 7.
- N=2, cut_out tied 1, GOLDEN=0 -> signature 16'h0003, pass=0, trojan_flag=1.
- Reset pulse during RUN at cycle 5 -> all outputs return to reset values asynchronously; a later start yields the same signature as an undisturbed run.
- start pulsed in cycles 0, 4 and N+CUT_LAT+4 -> only one run executes; done pulses once, and busy stays high continuously until DONE.
- LFSR_SEED=8'h00, N=3 -> cut_in sequence 1,2,4 (seed sanitised), and cut_rst_n is low for exactly cycles 1-2.
